// File: rtl/mem_rd_arb_fsm.sv
// Round-robin read arbiter: grants one requesting channel at a time and sequences
// a multi-beat memory read with per-beat wait-state timeout. Moore outputs only.
module mem_rd_arb_fsm #(
    parameter int NUM_CH = 4,
    parameter int LEN_W  = 4,
    parameter int TO_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] go,
    input  logic [LEN_W-1:0]  len,
    input  logic              ws,
    output logic              rd,
    output logic              ds,
    output logic [NUM_CH-1:0] grant,
    output logic [LEN_W-1:0]  beat,
    output logic              err,
    output logic              busy
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] TO_MAX_C = CNT_W'(TO_MAX);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        DLY  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  gidx_q, gidx_d;

    logic              found_s;
    logic [PTR_W-1:0]  sel_s;
    logic [PTR_W-1:0]  cand_s;

    // Round-robin search: first requester above the last granted channel, with wrap.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        cand_s  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand_s = PTR_W'((int'(ptr_q) + i) % NUM_CH);
            if (!found_s && go[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = READ;
                    grant_d = NUM_CH'(1'b1) << sel_s;
                    gidx_d  = sel_s;
                    len_d   = len;
                    beat_d  = '0;
                    wcnt_d  = '0;
                end else begin
                    grant_d = '0;
                end
            end
            READ: begin
                state_d = DLY;
                wcnt_d  = '0;
            end
            DLY: begin
                if (!ws) begin
                    if (beat_q == len_q) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + LEN_W'(1'b1);
                        state_d = READ;
                    end
                end else if (wcnt_q == TO_MAX_C) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1'b1);
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
                grant_d = '0;
                beat_d  = '0;
                ptr_d   = gidx_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                beat_d  = '0;
                wcnt_d  = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
            ptr_q   <= PTR_RST;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    // Moore output decode from the state register.
    always_comb begin
        rd   = 1'b0;
        ds   = 1'b0;
        err  = 1'b0;
        busy = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            READ, DLY: begin
                rd   = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                ds   = 1'b1;
                busy = 1'b1;
            end
            ERR: begin
                err  = 1'b1;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign grant = grant_q;
    assign beat  = beat_q;

endmodule

// File: tb/tb_mem_rd_arb_fsm.sv
// Bench for mem_rd_arb_fsm: vector table, directed corner sequences, and random
// traffic checked against a transaction-level expectation built up front.
module tb_mem_rd_arb_fsm;

    localparam int NCH  = 4;
    localparam int LW   = 4;
    localparam int TOM  = 15;
    localparam int NRND = 3000;
    localparam int NTOT = NRND + 400;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] go = 4'd0;
    logic [3:0] len = 4'd0;
    logic       ws = 1'b0;
    logic       rd, ds, err, busy;
    logic [3:0] grant, beat;

    always #5 clk = ~clk;

    mem_rd_arb_fsm #(.NUM_CH(NCH), .LEN_W(LW), .TO_MAX(TOM)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .len(len), .ws(ws),
        .rd(rd), .ds(ds), .grant(grant), .beat(beat), .err(err), .busy(busy)
    );

    typedef struct packed {
        logic       rd;
        logic       ds;
        logic       err;
        logic       busy;
        logic [3:0] grant;
        logic [3:0] beat;
    } obs_t;

    typedef struct {
        logic [3:0] go;
        logic [3:0] len;
        logic       ws;
        obs_t       e;
    } vec_t;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t tbl [0:21];
    logic [3:0] go_a  [0:NTOT-1];
    logic [3:0] len_a [0:NTOT-1];
    logic       ws_a  [0:NTOT-1];
    obs_t       exp_a [0:NTOT-1];

    function automatic obs_t mk(input logic r, input logic d, input logic e, input logic b,
                                input logic [3:0] g, input logic [3:0] bt);
        obs_t o;
        o.rd = r; o.ds = d; o.err = e; o.busy = b; o.grant = g; o.beat = bt;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {rd, ds, err, busy, grant, beat};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    endtask

    // beat is only meaningful while a transaction is in flight
    task automatic check_obs(input string name, input obs_t e);
        obs_t g;
        g = sample();
        if (!e.busy) begin
            g.beat = 4'd0;
            e.beat = 4'd0;
        end
        check(name, {20'd0, g}, {20'd0, e});
    endtask

    task automatic step(input logic [3:0] g, input logic [3:0] l, input logic w);
        @(posedge clk);
        #1;
        go = g; len = l; ws = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; go = 4'd0; len = 4'd0; ws = 1'b0;
        #1;
        check("reset_outputs", {20'd0, sample()}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int rd_cnt, ds_cnt, err_cnt, ds_at, err_at, beat_bad, nst;
        logic busy19;
        logic [3:0] prev_g;
        logic [3:0] gvals [0:7];
        int starts [0:7];
        logic [3:0] exp_g [0:4];

        // go, len, ws driven this cycle; expected outputs seen this cycle
        tbl[0]  = '{4'b0001, 4'd0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0)};
        tbl[1]  = '{4'b0000, 4'd5, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[2]  = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[3]  = '{4'b0000, 4'd0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[4]  = '{4'b0001, 4'd0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0)};
        tbl[5]  = '{4'b0000, 4'd0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[6]  = '{4'b0000, 4'd0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[7]  = '{4'b0000, 4'd0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[8]  = '{4'b0000, 4'd0, 1'b1, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[9]  = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[10] = '{4'b0000, 4'd0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0001, 4'd0)};
        tbl[11] = '{4'b0110, 4'd1, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0)};
        tbl[12] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd0)};
        tbl[13] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd0)};
        tbl[14] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd1)};
        tbl[15] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0010, 4'd1)};
        tbl[16] = '{4'b0000, 4'd0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0010, 4'd1)};
        tbl[17] = '{4'b0110, 4'd0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0)};
        tbl[18] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'd0)};
        tbl[19] = '{4'b0000, 4'd0, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'd0)};
        tbl[20] = '{4'b0000, 4'd0, 1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 4'd0)};
        tbl[21] = '{4'b0000, 4'd0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0)};
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].go, tbl[i].len, tbl[i].ws);
            check_obs($sformatf("table_row%0d", i), tbl[i].e);
        end

        // four-beat burst, go dropped right after grant
        do_reset();
        rd_cnt = 0; ds_cnt = 0; ds_at = -1; beat_bad = 0;
        for (int i = 0; i < 14; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000, (i == 0) ? 4'd3 : 4'd0, 1'b0);
            if (rd) begin
                if (beat !== 4'(rd_cnt / 2)) beat_bad++;
                rd_cnt++;
            end
            if (ds) begin ds_cnt++; ds_at = i; end
        end
        check("len3_rd_cycles", rd_cnt, 32'd8);
        check("len3_ds_count", ds_cnt, 32'd1);
        check("len3_ds_cycle", ds_at, 32'd9);
        check("len3_beat_seq_errors", beat_bad, 32'd0);

        // wait-state held high forever: timeout
        do_reset();
        rd_cnt = 0; ds_cnt = 0; err_cnt = 0; err_at = -1; busy19 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000, 4'd0, 1'b1);
            if (rd) rd_cnt++;
            if (ds) ds_cnt++;
            if (err) begin err_cnt++; err_at = i; end
            if (i == 19) busy19 = busy;
        end
        check("timeout_rd_cycles", rd_cnt, 32'd17);
        check("timeout_err_count", err_cnt, 32'd1);
        check("timeout_err_cycle", err_at, 32'd18);
        check("timeout_ds_count", ds_cnt, 32'd0);
        check("timeout_back_idle", {31'd0, busy19}, 32'd0);

        // all channels requesting continuously
        do_reset();
        nst = 0; prev_g = 4'd0;
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 4'd0, 1'b0);
            if (grant != 4'd0 && prev_g == 4'd0 && nst < 8) begin
                gvals[nst] = grant; starts[nst] = i; nst++;
            end
            prev_g = grant;
        end
        check("rr_grant_count", nst, 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < nst) begin
                check($sformatf("rr_grant%0d", k), {28'd0, gvals[k]}, {28'd0, exp_g[k]});
                if (k > 0) check($sformatf("rr_spacing%0d", k), starts[k] - starts[k-1], 32'd4);
            end
        end

        // reset asserted during DLY of beat 2
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step((i == 0) ? 4'b0001 : 4'b0000, (i == 0) ? 4'd3 : 4'd0, (i >= 6) ? 1'b1 : 1'b0);
        end
        check("midrst_pre_dly_beat2", {27'd0, rd, beat}, {27'd0, 1'b1, 4'd2});
        reset_n = 1'b0; go = 4'd0; ws = 1'b0;
        #1;
        check("midrst_outputs_zero", {20'd0, sample()}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ds_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'd0, 1'b0);
            if (ds || err || busy) ds_cnt++;
        end
        check("midrst_no_activity", ds_cnt, 32'd0);
        step(4'b0100, 4'd0, 1'b0);
        check_obs("midrst_idle_before_grant", mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'd0));
        step(4'b0000, 4'd0, 1'b0);
        check_obs("midrst_grant_ch2", mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'd0));
        step(4'b0000, 4'd0, 1'b0);
        step(4'b0000, 4'd0, 1'b0);
        check_obs("midrst_ch2_done", mk(1'b0, 1'b1, 1'b0, 1'b1, 4'b0100, 4'd0));

        // random traffic: stimulus fixed up front, expectation built per transaction
        for (int c = 0; c < NTOT; c++) begin
            go_a[c]  = (c < NRND && $urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            len_a[c] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            ws_a[c]  = (((c / 250) % 4) == 3 && (c % 250) < 40) ? 1'b1 : ($urandom_range(0, 99) < 35);
            exp_a[c] = '0;
        end
        begin : model
            int c, t, rr, ch, k, b, bl;
            bit tout, bdone;
            logic [3:0] g;
            c = 0; rr = NCH - 1;
            while (c < NRND) begin
                if (go_a[c] == 4'd0) begin
                    c++;
                end else begin
                    ch = -1;
                    for (int j = 1; j <= NCH; j++) begin
                        if (ch < 0 && go_a[c][(rr + j) % NCH]) ch = (rr + j) % NCH;
                    end
                    g = 4'(1 << ch);
                    bl = int'(len_a[c]);
                    t = c + 1; tout = 1'b0; b = 0;
                    while (!tout && b <= bl) begin
                        exp_a[t] = mk(1'b1, 1'b0, 1'b0, 1'b1, g, 4'(b));
                        t++;
                        k = 0; bdone = 1'b0;
                        while (!bdone) begin
                            exp_a[t] = mk(1'b1, 1'b0, 1'b0, 1'b1, g, 4'(b));
                            if (!ws_a[t]) bdone = 1'b1;
                            else if (k == TOM) begin bdone = 1'b1; tout = 1'b1; end
                            else k++;
                            t++;
                        end
                        if (!tout) b++;
                    end
                    if (tout) exp_a[t] = mk(1'b0, 1'b0, 1'b1, 1'b1, g, 4'(b));
                    else      exp_a[t] = mk(1'b0, 1'b1, 1'b0, 1'b1, g, 4'(bl));
                    t++;
                    rr = ch;
                    c = t;
                end
            end
        end
        do_reset();
        for (int c = 0; c < NRND; c++) begin
            step(go_a[c], len_a[c], ws_a[c]);
            check_obs($sformatf("rnd_cycle%0d", c), exp_a[c]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_rd_arb_fsm.md
MEM_RD_ARB_FSM -- requirements
Module: mem_rd_arb_fsm

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of requesting channels, legal range 2..8.
REQ-002 The block SHALL have parameter LEN_W, default 4: burst-length field width; burst beats = len+1.
REQ-003 The block SHALL have parameter TO_MAX, default 15: maximum consecutive wait-state cycles tolerated per beat.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port go  input  NUM_CH  per-channel read request, level-sensitive.
REQ-007 The block SHALL have port len  input  LEN_W  burst length minus one, sampled at grant.
REQ-008 The block SHALL have port ws  input  1  memory wait-state; high = data not ready.
REQ-009 The block SHALL have port rd  output  1  read strobe to memory.
REQ-010 The block SHALL have port ds  output  1  data-strobe / transaction complete pulse.
REQ-011 The block SHALL have port grant  output  NUM_CH  one-hot owner of the current transaction; all zero when idle.
REQ-012 The block SHALL have port beat  output  LEN_W  index of the current beat, 0-based.
REQ-013 The block SHALL have port err  output  1  wait-state timeout pulse.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL be a Moore machine: rd, ds, err, busy decoded from the state register only; grant and beat driven from registers; no input-to-output combinational path.
REQ-016 The state machine SHALL have the states IDLE, READ, DLY, DONE, ERR; unused encodings SHALL go to IDLE on the next edge.
REQ-017 Outputs per state SHALL be: IDLE all low; READ rd=1; DLY rd=1; DONE ds=1; ERR err=1; busy=1 in READ/DLY/DONE/ERR.
REQ-018 In IDLE with any go bit high, the block SHALL grant the first requesting channel found searching upward (with wrap) from the channel after the last granted one, latch len, clear beat and the wait counter, and go to READ.
REQ-019 In IDLE with go all zero, the block SHALL remain in IDLE with grant=0.
REQ-020 READ SHALL last exactly one cycle, then go to DLY with the wait counter cleared.
REQ-021 In DLY with ws=0 and beat==latched len, the block SHALL go to DONE.
REQ-022 In DLY with ws=0 and beat<latched len, the block SHALL increment beat and return to READ.
REQ-023 In DLY with ws=1 and wait counter<TO_MAX, the block SHALL increment the counter and stay in DLY.
REQ-024 In DLY with ws=1 and wait counter==TO_MAX, the block SHALL go to ERR, i.e. DLY lasts at most TO_MAX+1 cycles per beat.
REQ-025 DONE and ERR SHALL each last exactly one cycle, then go to IDLE; grant SHALL hold its value through DONE/ERR and clear on entry to IDLE.
REQ-026 The round-robin pointer SHALL update to the granted channel when leaving DONE or ERR.
REQ-027 Changes on go or len after grant SHALL be ignored until the next IDLE; a dropped go SHALL not abort the burst.
REQ-028 Minimum latency SHALL be as follows: go sampled high in IDLE at edge n gives rd high from n+1, and len=0 with ws=0 gives ds high in cycle n+3.
REQ-029 A channel holding go high continuously SHALL be re-granted no sooner than one IDLE cycle after DONE, and only if no other channel is requesting.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, rd=ds=err=busy=0, grant=0, beat=0, wait counter=0, and the pointer so that channel 0 has highest priority next.
REQ-031 Reset asserted mid-burst SHALL abandon the transaction without a ds or err pulse; after release, the first edge with go high SHALL start a fresh arbitration.

Verification
REQ-032 The bench SHALL cover this scenario: go=0001, len=0, ws=0 -> states READ,DLY,DONE; rd high 2 cycles, ds 1 cycle, grant=0001 for 3 cycles.
REQ-033 The bench SHALL cover this scenario: go=0001, len=3, ws=0 -> 4 READ/DLY pairs, beat 0..3, rd high 8 cycles, single ds.
REQ-034 The bench SHALL cover this scenario: go=0001, len=0, ws high 3 cycles in DLY -> DLY lasts 4 cycles, then DONE, err=0.
REQ-035 The bench SHALL cover this scenario: go=0001, ws held high, TO_MAX=15 -> ERR after 16 DLY cycles, err 1 cycle, ds never high, back to IDLE.
REQ-036 The bench SHALL cover this scenario: go=1111 held -> grants 0001,0010,0100,1000,0001 in order, each separated by an IDLE cycle.
REQ-037 The bench SHALL cover this scenario: reset_n pulsed low during DLY of beat 2 -> outputs zero immediately; next go=0100 grants channel 2 from IDLE.
